uart_cmd_sequencer: RTL and testbench
=====================================

# uart_cmd_sequencer

- Consumes the byte stream produced by the UART receiver (`uart_rx`: one-cycle data-valid strobe plus byte) and assembles debugger command frames.
- A frame is one opcode byte followed by 0, 4 or 8 big-endian argument bytes.
- Each complete frame is presented to the debugger core over a valid/ready handshake.
- Sits between `uart_rx` and the debug controller; detects bad opcodes, inter-byte timeouts and overruns.

## Interface
- `CLK_RATE`, 50000000: clock frequency in Hz.
- `TIMEOUT_CLKS`, CLK_RATE/100: inter-byte timeout in clocks (10 ms); minimum 2.
- `i_Clock`  in  1  system clock; all logic on the rising edge.
- `i_Reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_Rx_DV`  in  1  one-cycle byte strobe from `uart_rx`.
- `i_Rx_Byte`  in  8  received byte; valid when `i_Rx_DV`=1.
- `o_Cmd_Valid`  out  1  frame available.
- `i_Cmd_Ready`  in  1  debug core accepts the frame.
- `o_Cmd_Op`  out  8  opcode byte.
- `o_Cmd_Addr`  out  32  address argument; 0 if unused.
- `o_Cmd_Data`  out  32  data argument; 0 if unused.
- `o_Err`  out  1  one-cycle error pulse.
- `o_Err_Code`  out  2  error code, held until the next error: 1 = bad opcode, 2 = timeout, 3 = overrun.
- `o_Busy`  out  1  high in every state except IDLE.

## Operation
- Opcodes:
  - 0x01 READ: 4 argument bytes (address).
  - 0x02 WRITE: 4 address bytes, then 4 data bytes.
  - 0x03 PAUSE, 0x04 RESUME, 0x05 STATUS: no arguments.
- States:
  - IDLE:
    - DV with a valid 0-argument opcode: latch op, clear Addr/Data, go to ISSUE.
    - DV with a valid 1- or 2-word opcode: latch op, clear Addr/Data, go to ADDR.
    - DV with an invalid opcode: pulse error 1, stay in IDLE.
  - ADDR:
    - Each DV shifts in: `Addr <= {Addr[23:0], byte}`.
    - 2-bit byte counter; after the 4th byte go to DATA (WRITE) or ISSUE (READ).
  - DATA: same as ADDR for Data; after the 4th byte go to ISSUE.
  - ISSUE:
    - `o_Cmd_Valid`=1; Op/Addr/Data held stable.
    - On `i_Cmd_Ready`=1, the handshake completes and the state returns to IDLE.
- Timeout:
  - Counter runs in ADDR and DATA only; cleared on every DV and on entry to those states.
  - When the count reaches TIMEOUT_CLKS-1 with no DV: pulse error 2, discard the partial frame, go to IDLE.
  - Width is $clog2(TIMEOUT_CLKS); no wrap.
- Overrun: DV in ISSUE with `i_Cmd_Ready`=0 drops the byte, pulses error 3, and stays in ISSUE.
- Simultaneous events:
  - DV with `i_Cmd_Ready`=1 in ISSUE: the handshake completes and the byte is decoded exactly as in IDLE, in the same cycle. No error.
  - DV and timeout expiry in the same cycle: the DV wins (byte accepted, counter cleared).
- Reset mid-frame: all state is cleared immediately and the partial frame is lost.

## Timing
- Reset values:
  - `o_Cmd_Valid`=0, `o_Cmd_Op`=0, `o_Cmd_Addr`=0, `o_Cmd_Data`=0.
  - `o_Err`=0, `o_Err_Code`=0, `o_Busy`=0.
  - Internal state: IDLE.
- All outputs are registered.
- `o_Cmd_Valid` rises the cycle after the DV of the final frame byte; for a 0-argument opcode, the cycle after the opcode DV.
- Valid stays high until the first cycle with `i_Cmd_Ready`=1 (inclusive); it is low the next cycle.
- Back-to-back frames are possible with no idle cycle.
- `o_Err` is high exactly one cycle, the cycle after the triggering DV or the timeout expiry.

## Structure
- Package `uart_dbg_pkg`:
  - Opcode localparams.
  - Per-opcode argument-count function (0/1/2 words).
  - State enum.
  - Error-code enum.
- Sub-module `uart_byte_timeout`: loadable down-counter with clear, enable and an expire output.
- Top level holds the FSM, the shift registers and the handshake.
- Estimated 150–250 lines total.

## Test plan
- Use TIMEOUT_CLKS=64 in the bench.
- PAUSE: byte 0x03 with Ready=1 -> Valid for one cycle, Op=0x03, Addr=0, Data=0, no error.
- WRITE: bytes 02 80 00 10 00 DE AD BE EF -> Op=0x02, Addr=0x80001000, Data=0xDEADBEEF, Valid the cycle after the last DV.
- READ: bytes 01 00 00 00 04, Ready low for 5 cycles, extra byte 0x05 during the wait -> error 3; the frame holds Addr=0x00000004 until Ready.
- Timeout: 01 AA then silence -> error 2 exactly 63 cycles after the 0xAA DV; Busy falls; a following 03 is accepted normally.
- Bad opcode: 0xFF -> error 1 the next cycle, state stays IDLE; no Valid.
- Reset mid-frame: 02 11 22, reset pulse, then 04 -> RESUME issued with Addr=0 and Data=0.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug command sequencer:
// opcodes, argument-word lookup, FSM states and error codes.
package uart_dbg_pkg;

    localparam logic [7:0] OP_READ   = 8'h01;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_PAUSE  = 8'h03;
    localparam logic [7:0] OP_RESUME = 8'h04;
    localparam logic [7:0] OP_STATUS = 8'h05;

    // 3 marks an opcode the debugger does not know
    localparam logic [1:0] WORDS_BAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_OP  = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_t;

    function automatic logic [1:0] op_words(input logic [7:0] op);
        logic [1:0] w;
        w = WORDS_BAD;
        case (op)
            OP_READ:   w = 2'd1;
            OP_WRITE:  w = 2'd2;
            OP_PAUSE,
            OP_RESUME,
            OP_STATUS: w = 2'd0;
            default:   w = WORDS_BAD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: loadable down-counter that saturates at zero.
// expire is asserted while enabled and the count has run out.
module uart_byte_timeout #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Assembles opcode + big-endian argument bytes from uart_rx into
// debugger command frames and hands them off over valid/ready.
module uart_cmd_sequencer
    import uart_dbg_pkg::*;
#(
    parameter int CLK_RATE     = 50000000,
    parameter int TIMEOUT_CLKS = CLK_RATE / 100
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Cmd_Valid,
    input  logic        i_Cmd_Ready,
    output logic [7:0]  o_Cmd_Op,
    output logic [31:0] o_Cmd_Addr,
    output logic [31:0] o_Cmd_Data,
    output logic        o_Err,
    output logic [1:0]  o_Err_Code,
    output logic        o_Busy
);

    localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    // Load with N-2 so the error flop fires N-1 cycles after the last DV
    localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CLKS - 2);

    state_t      state, state_n;
    err_t        code, code_n;
    logic [7:0]  op, op_n;
    logic [31:0] addr, addr_n;
    logic [31:0] data, data_n;
    logic [1:0]  bcnt, bcnt_n;
    logic        err_n;
    logic        decode;
    logic        tmo_load;
    logic        tmo_en;
    logic        expire;

    assign tmo_en = (state == ST_ADDR) || (state == ST_DATA);

    uart_byte_timeout #(
        .WIDTH(TW)
    ) u_timeout (
        .clk     (i_Clock),
        .rst_n   (i_Reset_n),
        .load    (tmo_load),
        .load_val(TLOAD),
        .en      (tmo_en),
        .expire  (expire)
    );

    always_comb begin
        state_n  = state;
        op_n     = op;
        addr_n   = addr;
        data_n   = data;
        bcnt_n   = bcnt;
        code_n   = code;
        err_n    = 1'b0;
        decode   = 1'b0;
        tmo_load = 1'b0;

        case (state)
            ST_IDLE: begin
                decode = i_Rx_DV;
            end
            ST_ADDR: begin
                if (i_Rx_DV) begin
                    addr_n   = {addr[23:0], i_Rx_Byte};
                    bcnt_n   = bcnt + 2'd1;
                    tmo_load = 1'b1;
                    if (bcnt == 2'd3) begin
                        state_n = (op_words(op) == 2'd2) ? ST_DATA : ST_ISSUE;
                    end
                end else if (expire) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = ST_IDLE;
                    op_n    = '0;
                    addr_n  = '0;
                    data_n  = '0;
                end
            end
            ST_DATA: begin
                if (i_Rx_DV) begin
                    data_n   = {data[23:0], i_Rx_Byte};
                    bcnt_n   = bcnt + 2'd1;
                    tmo_load = 1'b1;
                    if (bcnt == 2'd3) begin
                        state_n = ST_ISSUE;
                    end
                end else if (expire) begin
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = ST_IDLE;
                    op_n    = '0;
                    addr_n  = '0;
                    data_n  = '0;
                end
            end
            ST_ISSUE: begin
                if (i_Cmd_Ready) begin
                    state_n = ST_IDLE;
                    decode  = i_Rx_DV;
                end else if (i_Rx_DV) begin
                    err_n  = 1'b1;
                    code_n = ERR_OVERRUN;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Shared opcode decode: plain IDLE and a completing handshake
        if (decode) begin
            case (op_words(i_Rx_Byte))
                2'd0: begin
                    op_n    = i_Rx_Byte;
                    addr_n  = '0;
                    data_n  = '0;
                    state_n = ST_ISSUE;
                end
                2'd1, 2'd2: begin
                    op_n     = i_Rx_Byte;
                    addr_n   = '0;
                    data_n   = '0;
                    bcnt_n   = '0;
                    tmo_load = 1'b1;
                    state_n  = ST_ADDR;
                end
                default: begin
                    err_n   = 1'b1;
                    code_n  = ERR_BAD_OP;
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state       <= ST_IDLE;
            op          <= '0;
            addr        <= '0;
            data        <= '0;
            bcnt        <= '0;
            code        <= ERR_NONE;
            o_Err       <= 1'b0;
            o_Cmd_Valid <= 1'b0;
            o_Busy      <= 1'b0;
        end else begin
            state       <= state_n;
            op          <= op_n;
            addr        <= addr_n;
            data        <= data_n;
            bcnt        <= bcnt_n;
            code        <= code_n;
            o_Err       <= err_n;
            o_Cmd_Valid <= (state_n == ST_ISSUE);
            o_Busy      <= (state_n != ST_IDLE);
        end
    end

    assign o_Cmd_Op   = op;
    assign o_Cmd_Addr = addr;
    assign o_Cmd_Data = data;
    assign o_Err_Code = code;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: frame table plus
// hand-written overrun, timeout, bad-opcode and reset sequences.
module tb_uart_cmd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        dv;
    logic [7:0]  rx_byte;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    int checks;
    int failures;

    uart_cmd_sequencer #(
        .CLK_RATE    (6400),
        .TIMEOUT_CLKS(64)
    ) dut (
        .i_Clock    (clk),
        .i_Reset_n  (rst_n),
        .i_Rx_DV    (dv),
        .i_Rx_Byte  (rx_byte),
        .o_Cmd_Valid(cmd_valid),
        .i_Cmd_Ready(cmd_ready),
        .o_Cmd_Op   (cmd_op),
        .o_Cmd_Addr (cmd_addr),
        .o_Cmd_Data (cmd_data),
        .o_Err      (err),
        .o_Err_Code (err_code),
        .o_Busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        logic [71:0] bytes;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one byte strobe; returns 1 time unit after the sampling edge
    task automatic send(input logic [7:0] b);
        dv      = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        dv      = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int first_err;
        checks    = 0;
        failures  = 0;
        dv        = 1'b0;
        rx_byte   = 8'h00;
        cmd_ready = 1'b1;
        rst_n     = 1'b0;

        vecs[0] = '{"pause",  1, 72'h03_00_00_00_00_00_00_00_00,
                    8'h03, 32'h0, 32'h0};
        vecs[1] = '{"resume", 1, 72'h04_00_00_00_00_00_00_00_00,
                    8'h04, 32'h0, 32'h0};
        vecs[2] = '{"status", 1, 72'h05_00_00_00_00_00_00_00_00,
                    8'h05, 32'h0, 32'h0};
        vecs[3] = '{"read",   5, 72'h01_12_34_56_78_00_00_00_00,
                    8'h01, 32'h12345678, 32'h0};
        vecs[4] = '{"write",  9, 72'h02_80_00_10_00_DE_AD_BE_EF,
                    8'h02, 32'h80001000, 32'hDEADBEEF};
        vecs[5] = '{"write2", 9, 72'h02_00_00_00_01_00_00_00_02,
                    8'h02, 32'h00000001, 32'h00000002};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_op",    32'(cmd_op),    32'd0);
        chk("rst_addr",  cmd_addr,       32'd0);
        chk("rst_data",  cmd_data,       32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_code",  32'(err_code),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;
        idle(2);

        // Frame table, Ready held high
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                logic [71:0] bb;
                bb = vecs[i].bytes << (8 * k);
                send(bb[71:64]);
                if (k < vecs[i].n - 1) begin
                    chk({vecs[i].name, "_busy_mid"}, 32'(busy), 32'd1);
                    chk({vecs[i].name, "_valid_mid"}, 32'(cmd_valid), 32'd0);
                end
            end
            chk({vecs[i].name, "_valid"}, 32'(cmd_valid), 32'd1);
            chk({vecs[i].name, "_op"},    32'(cmd_op),    32'(vecs[i].op));
            chk({vecs[i].name, "_addr"},  cmd_addr,       vecs[i].addr);
            chk({vecs[i].name, "_data"},  cmd_data,       vecs[i].data);
            chk({vecs[i].name, "_err"},   32'(err),       32'd0);
            idle(1);
            chk({vecs[i].name, "_valid_drop"}, 32'(cmd_valid), 32'd0);
            chk({vecs[i].name, "_busy_drop"},  32'(busy),      32'd0);
            idle(1);
        end

        // READ with Ready low and an overrunning byte
        cmd_ready = 1'b0;
        send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h04);
        chk("ovr_valid", 32'(cmd_valid), 32'd1);
        idle(1);
        send(8'h05);
        chk("ovr_err",   32'(err),      32'd1);
        chk("ovr_code",  32'(err_code), 32'd3);
        chk("ovr_valid_hold", 32'(cmd_valid), 32'd1);
        chk("ovr_op",    32'(cmd_op),   32'h01);
        chk("ovr_addr",  cmd_addr,      32'h00000004);
        idle(1);
        chk("ovr_err_pulse", 32'(err), 32'd0);
        idle(2);
        chk("ovr_valid_wait", 32'(cmd_valid), 32'd1);
        chk("ovr_addr_wait",  cmd_addr,       32'h00000004);
        cmd_ready = 1'b1;
        idle(1);
        chk("ovr_valid_drop", 32'(cmd_valid), 32'd0);
        chk("ovr_code_hold",  32'(err_code),  32'd3);
        idle(1);

        // Timeout after READ opcode + one address byte
        send(8'h01);
        send(8'hAA);
        first_err = 0;
        for (int k = 1; k <= 70; k++) begin
            idle(1);
            if (err && first_err == 0) begin
                first_err = k;
                chk("tmo_code", 32'(err_code), 32'd2);
                chk("tmo_busy", 32'(busy),     32'd0);
            end
        end
        chk("tmo_cycle", 32'(first_err), 32'd63);
        send(8'h03);
        chk("tmo_next_valid", 32'(cmd_valid), 32'd1);
        chk("tmo_next_op",    32'(cmd_op),    32'h03);
        idle(2);

        // DV in the same cycle the timeout would expire: byte wins
        send(8'h01);
        send(8'hAA);
        idle(62);
        send(8'hBB);
        chk("race_err",  32'(err),  32'd0);
        chk("race_busy", 32'(busy), 32'd1);
        send(8'hCC);
        send(8'hDD);
        chk("race_valid", 32'(cmd_valid), 32'd1);
        chk("race_addr",  cmd_addr,       32'hAABBCCDD);
        idle(2);

        // Bad opcode
        send(8'hFF);
        chk("bad_err",   32'(err),       32'd1);
        chk("bad_code",  32'(err_code),  32'd1);
        chk("bad_valid", 32'(cmd_valid), 32'd0);
        chk("bad_busy",  32'(busy),      32'd0);
        idle(1);
        chk("bad_pulse", 32'(err),       32'd0);
        chk("bad_hold",  32'(err_code),  32'd1);

        // Back-to-back: new opcode arrives as the handshake completes
        send(8'h03);
        send(8'h05);
        chk("b2b_valid", 32'(cmd_valid), 32'd1);
        chk("b2b_op",    32'(cmd_op),    32'h05);
        chk("b2b_err",   32'(err),       32'd0);
        idle(2);

        // Reset mid-frame
        send(8'h02); send(8'h11); send(8'h22);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy),     32'd0);
        chk("mid_rst_addr", cmd_addr,      32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send(8'h04);
        chk("mid_valid", 32'(cmd_valid), 32'd1);
        chk("mid_op",    32'(cmd_op),    32'h04);
        chk("mid_addr",  cmd_addr,       32'd0);
        chk("mid_data",  cmd_data,       32'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
